// File: rtl/cpu_pkg.sv
// Shared widths, index/data types and ALU opcode encodings for the 4-bit CPU.
package cpu_pkg;

    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [1:0]        alu_op_t;

    localparam alu_op_t ALU_ADD  = 2'b00;
    localparam alu_op_t ALU_NAND = 2'b01;
    localparam alu_op_t ALU_NOOP = 2'b10;
    localparam alu_op_t ALU_SHL  = 2'b11;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control-unit <-> datapath bus: selects, immediate, write control and register/flag observation.
// C and Z exist only when DATAPATH_FLAGS_EN is defined.
interface cpu_datapath_if;
    import cpu_pkg::*;

    idx_t    SEL_A;
    idx_t    SEL_B;
    idx_t    SEL_W;
    data_t   IMM;
    logic    sel_data;
    logic    write_en;
    alu_op_t alu_op;
    data_t   R0;
    data_t   R1;
    data_t   R2;
    data_t   R3;
`ifdef DATAPATH_FLAGS_EN
    logic    C;
    logic    Z;
`endif

    modport master (
        output SEL_A, SEL_B, SEL_W, IMM, sel_data, write_en, alu_op,
        input  R0, R1, R2, R3
`ifdef DATAPATH_FLAGS_EN
        , input C, Z
`endif
    );

    modport slave (
        input  SEL_A, SEL_B, SEL_W, IMM, sel_data, write_en, alu_op,
        output R0, R1, R2, R3
`ifdef DATAPATH_FLAGS_EN
        , output C, Z
`endif
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational 4-bit ALU: ADD, NAND, pass-through of A, and shift-left by one.
module cpu_alu
    import cpu_pkg::*;
(
    input  data_t   i_a,
    input  data_t   i_b,
    input  alu_op_t i_op,
    output data_t   o_result,
    output logic    o_carry
);

    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            ALU_NAND: o_result = ~(i_a & i_b);
            ALU_NOOP: o_result = i_a;
            ALU_SHL: begin
                o_result = {i_a[DATA_W-2:0], 1'b0};
                o_carry  = i_a[DATA_W-1];
            end
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Four-entry register file, write-data mux and ALU of the 4-bit CPU.
// Optional registered C/Z flags are built when DATAPATH_FLAGS_EN is defined.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cpu_datapath_if.slave bus
);

    data_t r_regs [NUM_REGS];
    data_t w_op_a;
    data_t w_op_b;
    data_t w_alu_result;
    logic  w_alu_carry;
    data_t w_wdata;

    assign w_op_a  = r_regs[bus.SEL_A];
    assign w_op_b  = r_regs[bus.SEL_B];
    assign w_wdata = bus.sel_data ? bus.IMM : w_alu_result;

    cpu_alu u_alu (
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .i_op     (bus.alu_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // Operands are read before the edge, so a register may be both source and destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.write_en) begin
            r_regs[bus.SEL_W] <= w_wdata;
        end
    end

    assign bus.R0 = r_regs[0];
    assign bus.R1 = r_regs[1];
    assign bus.R2 = r_regs[2];
    assign bus.R3 = r_regs[3];

`ifdef DATAPATH_FLAGS_EN
    logic r_c;
    logic r_z;

    // Flags track ALU writes only; immediate loads and idle cycles leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
        end else if (bus.write_en && !bus.sel_data) begin
            r_c <= w_alu_carry;
            r_z <= (w_alu_result == '0);
        end
    end

    assign bus.C = r_c;
    assign bus.Z = r_z;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_alu_carry;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath; flag checks compile in with DATAPATH_FLAGS_EN.
module tb_cpu_datapath;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_datapath_if bus ();

    cpu_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input data_t e0, input data_t e1,
                            input data_t e2, input data_t e3);
        chk({tag, ".R0"}, bus.R0, e0);
        chk({tag, ".R1"}, bus.R1, e1);
        chk({tag, ".R2"}, bus.R2, e2);
        chk({tag, ".R3"}, bus.R3, e3);
    endtask

    task automatic chk_flags(input string tag, input logic ec, input logic ez);
`ifdef DATAPATH_FLAGS_EN
        chk({tag, ".C"}, {3'b000, bus.C}, {3'b000, ec});
        chk({tag, ".Z"}, {3'b000, bus.Z}, {3'b000, ez});
`else
        if (ec === 1'bx || ez === 1'bx || tag.len() == 0) begin
            n_vec = n_vec + 0;
        end
`endif
    endtask

    task automatic apply(input idx_t a, input idx_t b, input idx_t w, input data_t imm,
                         input logic sd, input logic we, input alu_op_t op);
        @(negedge clk);
        bus.SEL_A    = a;
        bus.SEL_B    = b;
        bus.SEL_W    = w;
        bus.IMM      = imm;
        bus.sel_data = sd;
        bus.write_en = we;
        bus.alu_op   = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.SEL_A    = 2'd0;
        bus.SEL_B    = 2'd0;
        bus.SEL_W    = 2'd0;
        bus.IMM      = 4'h5;
        bus.sel_data = 1'b1;
        bus.write_en = 1'b1;
        bus.alu_op   = ALU_ADD;
        #1 rst_n = 1'b0;
        #1;
        chk_regs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_flags("reset", 1'b0, 1'b0);

        // Write attempted while reset is held must not land
        @(posedge clk);
        #1;
        chk("wr_in_reset.R0", bus.R0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.write_en = 1'b0;

        // Put non-zero state in place, then reset mid-cycle
        apply(2'd0, 2'd0, 2'd0, 4'h7, 1'b1, 1'b1, ALU_ADD);
        chk("pre.R0", bus.R0, 4'h7);
        apply(2'd0, 2'd0, 2'd3, 4'h0, 1'b0, 1'b1, ALU_ADD);
        chk("pre.R3", bus.R3, 4'hE);
        apply(2'd3, 2'd0, 2'd1, 4'h0, 1'b0, 1'b1, ALU_SHL);
        chk_regs("pre", 4'h7, 4'hC, 4'h0, 4'hE);
        chk_flags("pre", 1'b1, 1'b0);

        @(negedge clk);
        bus.SEL_W    = 2'd2;
        bus.IMM      = 4'h5;
        bus.sel_data = 1'b1;
        bus.write_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_regs("midrst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_flags("midrst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_wr.R2", bus.R2, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.write_en = 1'b0;

        // Immediate loads 0, -1, 2, -3
        apply(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b1, ALU_ADD);
        apply(2'd0, 2'd0, 2'd1, 4'hF, 1'b1, 1'b1, ALU_ADD);
        apply(2'd0, 2'd0, 2'd2, 4'h2, 1'b1, 1'b1, ALU_ADD);
        apply(2'd0, 2'd0, 2'd3, 4'hD, 1'b1, 1'b1, ALU_ADD);
        chk_regs("imm", 4'h0, 4'hF, 4'h2, 4'hD);
        chk_flags("imm", 1'b0, 1'b0);

        apply(2'd1, 2'd2, 2'd0, 4'h0, 1'b0, 1'b1, ALU_ADD);
        chk_regs("add1", 4'h1, 4'hF, 4'h2, 4'hD);
        chk_flags("add1", 1'b1, 1'b0);
        apply(2'd0, 2'd1, 2'd2, 4'h0, 1'b0, 1'b1, ALU_ADD);
        chk_regs("add2", 4'h1, 4'hF, 4'h0, 4'hD);
        chk_flags("add2", 1'b1, 1'b1);

        apply(2'd1, 2'd3, 2'd0, 4'h0, 1'b0, 1'b1, ALU_NAND);
        chk_regs("nand", 4'h2, 4'hF, 4'h0, 4'hD);
        chk_flags("nand", 1'b0, 1'b0);
        apply(2'd3, 2'd0, 2'd1, 4'h0, 1'b0, 1'b1, ALU_NOOP);
        chk_regs("noop", 4'h2, 4'hD, 4'h0, 4'hD);
        chk_flags("noop", 1'b0, 1'b0);

        apply(2'd3, 2'd1, 2'd3, 4'h0, 1'b0, 1'b1, ALU_SHL);
        chk_regs("shl1", 4'h2, 4'hD, 4'h0, 4'hA);
        chk_flags("shl1", 1'b1, 1'b0);
        apply(2'd3, 2'd0, 2'd3, 4'h0, 1'b0, 1'b1, ALU_SHL);
        chk_regs("shl2", 4'h2, 4'hD, 4'h0, 4'h4);
        chk_flags("shl2", 1'b1, 1'b0);

        // Idle cycles with varied selects hold everything
        apply(2'd1, 2'd2, 2'd0, 4'h9, 1'b0, 1'b0, ALU_ADD);
        apply(2'd2, 2'd2, 2'd1, 4'h6, 1'b1, 1'b0, ALU_NAND);
        apply(2'd0, 2'd3, 2'd3, 4'h0, 1'b0, 1'b0, ALU_SHL);
        chk_regs("hold", 4'h2, 4'hD, 4'h0, 4'h4);
        chk_flags("hold", 1'b1, 1'b0);

        apply(2'd0, 2'd0, 2'd2, 4'h4, 1'b1, 1'b1, ALU_SHL);
        chk_regs("ld4", 4'h2, 4'hD, 4'h4, 4'h4);
        chk_flags("ld4", 1'b1, 1'b0);
        apply(2'd2, 2'd2, 2'd2, 4'h0, 1'b0, 1'b1, ALU_ADD);
        chk_regs("rdw", 4'h2, 4'hD, 4'h8, 4'h4);
        chk_flags("rdw", 1'b0, 1'b0);

        apply(2'd2, 2'd0, 2'd2, 4'h0, 1'b0, 1'b1, ALU_SHL);
        chk_regs("shl0", 4'h2, 4'hD, 4'h0, 4'h4);
        chk_flags("shl0", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
